fetch_pc_unit: RTL and testbench

- Owns the program counter of the MIPS fetch stage; the consumer of the branch target that decode computes from PC+4 and the sign-extended offset.
- Each advancing cycle it selects the next PC:
  - sequential (PC+4),
  - branch target,
  - jump target,
  - register-jump target,
  - or hold.
- Supplies PC and PC+4 to instruction memory and to the IF/ID latch.
- Honours the hazard-unit stall, the debug-unit run/step control and the HALT instruction.

---
 rtl/fetch_pc_unit_if.sv | 37 +++
 rtl/fetch_pc_unit.sv | 93 +++++++++
 tb/tb_fetch_pc_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Purpose: groups the fetch PC unit's control, redirect and status signals into one bundle.
// Ports: slave = fetch_pc_unit side; master = the decode, hazard and debug side that drives the controls.
// Signals: run/step/stall/halt controls, three redirect requests with targets, PC outputs and status.
interface fetch_pc_unit_if #(
  parameter int DATA_WIDTH = 32
);
  // Debug, hazard and decode controls into the unit
  logic                  i_enable;
  logic                  i_step;
  logic                  i_stall;
  logic                  i_branch_taken;
  logic [DATA_WIDTH-1:0] i_pcbranch;
  logic                  i_jump;
  logic [DATA_WIDTH-1:0] i_pcjump;
  logic                  i_jump_reg;
  logic [DATA_WIDTH-1:0] i_pcreg;
  logic                  i_halt;
  // Fetch address and status out of the unit
  logic [DATA_WIDTH-1:0] o_pc;
  logic [DATA_WIDTH-1:0] o_pcplus4;
  logic                  o_flush;
  logic                  o_misaligned;
  logic                  o_halted;
  logic [DATA_WIDTH-1:0] o_cycle_count;

  modport master (
    output i_enable, i_step, i_stall, i_branch_taken, i_pcbranch,
           i_jump, i_pcjump, i_jump_reg, i_pcreg, i_halt,
    input  o_pc, o_pcplus4, o_flush, o_misaligned, o_halted, o_cycle_count
  );

  modport slave (
    input  i_enable, i_step, i_stall, i_branch_taken, i_pcbranch,
           i_jump, i_pcjump, i_jump_reg, i_pcreg, i_halt,
    output o_pc, o_pcplus4, o_flush, o_misaligned, o_halted, o_cycle_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Purpose: MIPS fetch-stage program counter with next-PC selection, stall, debug run/step and HALT.
// Latency: a redirect shows on o_pc one cycle after it is accepted; o_flush is combinational.
// Backpressure: i_stall holds the PC without flushing; HALT freezes the unit until i_reset.
// Ports: i_clk, i_reset (sync, active-high), bus (fetch_pc_unit_if.slave).
module fetch_pc_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  fetch_pc_unit_if.slave  bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  mis_q, mis_d;

  logic                  advance;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] target;
  logic                  flush;

  // Reset wins over everything, so it also masks the combinational flush
  assign advance = (bus.i_enable | bus.i_step) & (state_q == ST_RUN) & ~i_reset;

  // Redirect target in priority order: register jump, jump, branch
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    if (bus.i_jump_reg) begin
      redirect = 1'b1;
      target   = bus.i_pcreg;
    end else if (bus.i_jump) begin
      redirect = 1'b1;
      target   = bus.i_pcjump;
    end else if (bus.i_branch_taken) begin
      redirect = 1'b1;
      target   = bus.i_pcbranch;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;     // misaligned is a single-cycle pulse
    flush   = 1'b0;
    if (advance) begin
      cnt_d = cnt_q + DATA_WIDTH'(1);
      if (bus.i_stall) begin
        // Decode will re-present redirect/HALT next cycle
        pc_d = pc_q;
      end else if (bus.i_halt) begin
        state_d = ST_HALTED;
        flush   = 1'b1;
      end else if (redirect) begin
        pc_d  = {target[DATA_WIDTH-1:2], 2'b00};
        mis_d = |target[1:0];
        flush = 1'b1;
      end else begin
        pc_d = pc_q + DATA_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_pcplus4     = pc_q + DATA_WIDTH'(4);
  assign bus.o_flush       = flush;
  assign bus.o_misaligned  = mis_q;
  assign bus.o_halted      = (state_q == ST_HALTED);
  assign bus.o_cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Purpose: self-checking bench for fetch_pc_unit: directed scenarios plus randomized traffic vs a reference model.
// Latency: inputs driven on the falling edge, all outputs compared 1 time unit later.
// Backpressure: stall/halt/step behaviour is covered by both the directed and random phases.
module tb_fetch_pc_unit;

  localparam int DW = 32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fetch_pc_unit_if #(.DATA_WIDTH(DW)) bus ();

  fetch_pc_unit #(.DATA_WIDTH(DW), .RESET_PC('0)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what the fetch unit should be showing right now
  logic [DW-1:0] m_pc;
  logic [DW-1:0] m_cnt;
  logic          m_mis;
  logic          m_halted;
  logic          m_valid;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_in();
    bus.i_enable       = 1'b0;
    bus.i_step         = 1'b0;
    bus.i_stall        = 1'b0;
    bus.i_branch_taken = 1'b0;
    bus.i_pcbranch     = '0;
    bus.i_jump         = 1'b0;
    bus.i_pcjump       = '0;
    bus.i_jump_reg     = 1'b0;
    bus.i_pcreg        = '0;
    bus.i_halt         = 1'b0;
    rst                = 1'b0;
  endtask

  // Compare every output against the model for the inputs currently applied,
  // then take the clock edge and move the model forward by the same rules.
  task automatic tick();
    logic          adv;
    logic          redir;
    logic [DW-1:0] tgt;
    logic          exp_flush;
    adv = (bus.i_enable || bus.i_step) && !m_halted && !rst;
    redir = bus.i_jump_reg || bus.i_jump || bus.i_branch_taken;
    tgt = bus.i_jump_reg ? bus.i_pcreg : (bus.i_jump ? bus.i_pcjump : bus.i_pcbranch);
    exp_flush = adv && !bus.i_stall && (bus.i_halt || redir);
    #1;
    if (m_valid) begin
      check("pc",      bus.o_pc,          m_pc);
      check("pcplus4", bus.o_pcplus4,     m_pc + 32'd4);
      check("count",   bus.o_cycle_count, m_cnt);
      check("misalgn", {31'd0, bus.o_misaligned}, {31'd0, m_mis});
      check("halted",  {31'd0, bus.o_halted},     {31'd0, m_halted});
      check("flush",   {31'd0, bus.o_flush},      {31'd0, exp_flush});
    end
    @(posedge clk);
    if (rst) begin
      m_pc = 32'd0; m_cnt = 32'd0; m_mis = 1'b0; m_halted = 1'b0; m_valid = 1'b1;
    end else begin
      m_mis = 1'b0;
      if (adv) begin
        m_cnt = m_cnt + 32'd1;
        if (!bus.i_stall) begin
          if (bus.i_halt) m_halted = 1'b1;
          else if (redir) begin
            m_pc  = tgt & 32'hFFFF_FFFC;
            m_mis = (tgt % 4) != 0;
          end else m_pc = m_pc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_pc = '0; m_cnt = '0; m_mis = 1'b0; m_halted = 1'b0; m_valid = 1'b0;
    clear_in();
    @(negedge clk);
    do_reset();

    // Sequential run: 0,4,8,12,16
    bus.i_enable = 1'b1;
    repeat (4) tick();
    #1;
    check("seq_pc16", bus.o_pc, 32'h10);
    check("seq_cnt4", bus.o_cycle_count, 32'd4);

    // Branch at 0x10 to 0x40
    bus.i_branch_taken = 1'b1; bus.i_pcbranch = 32'h40;
    tick();
    bus.i_branch_taken = 1'b0;
    #1;
    check("br_pc",  bus.o_pc, 32'h40);
    check("br_pp4", bus.o_pcplus4, 32'h44);

    // Stall against a branch at 0x20, then re-presented branch
    bus.i_jump = 1'b1; bus.i_pcjump = 32'h20;
    tick();
    bus.i_jump = 1'b0;
    bus.i_stall = 1'b1; bus.i_branch_taken = 1'b1; bus.i_pcbranch = 32'h80;
    tick();
    #1;
    check("stall_pc", bus.o_pc, 32'h20);
    bus.i_stall = 1'b0;
    tick();
    bus.i_branch_taken = 1'b0;
    #1;
    check("stall_br", bus.o_pc, 32'h80);

    // All three redirects together; misaligned register target wins
    bus.i_jump = 1'b1; bus.i_pcjump = 32'h100;
    bus.i_jump_reg = 1'b1; bus.i_pcreg = 32'h203;
    bus.i_branch_taken = 1'b1; bus.i_pcbranch = 32'h300;
    tick();
    clear_in(); bus.i_enable = 1'b1;
    #1;
    check("jr_pc",  bus.o_pc, 32'h200);
    check("jr_mis", {31'd0, bus.o_misaligned}, 32'd1);
    tick();
    #1;
    check("mis_clr", {31'd0, bus.o_misaligned}, 32'd0);

    // PC+4 wraps at the top of the address space
    bus.i_jump = 1'b1; bus.i_pcjump = 32'hFFFF_FFFC;
    tick();
    bus.i_jump = 1'b0;
    #1;
    check("wrap_pp4", bus.o_pcplus4, 32'h0);
    tick();
    #1;
    check("wrap_pc", bus.o_pc, 32'h0);

    // Single-step mode: one step every third cycle
    bus.i_enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.i_step = (i % 3 == 0);
      tick();
    end
    bus.i_step = 1'b0;
    #1;
    check("step_pc", bus.o_pc, 32'h10);

    // HALT at 0x30, hold for 10 cycles, exit via reset
    bus.i_enable = 1'b1;
    bus.i_jump = 1'b1; bus.i_pcjump = 32'h30;
    tick();
    bus.i_jump = 1'b0;
    bus.i_halt = 1'b1;
    tick();
    bus.i_halt = 1'b0;
    repeat (10) tick();
    #1;
    check("halt_pc",  bus.o_pc, 32'h30);
    check("halt_flg", {31'd0, bus.o_halted}, 32'd1);
    do_reset();
    #1;
    check("rst_pc",  bus.o_pc, 32'h0);
    check("rst_hlt", {31'd0, bus.o_halted}, 32'd0);
    check("rst_cnt", bus.o_cycle_count, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.i_enable       = ($urandom_range(0, 3) != 0);
      bus.i_step         = ($urandom_range(0, 3) == 0);
      bus.i_stall        = ($urandom_range(0, 4) == 0);
      bus.i_branch_taken = ($urandom_range(0, 3) == 0);
      bus.i_pcbranch     = $urandom;
      bus.i_jump         = ($urandom_range(0, 5) == 0);
      bus.i_pcjump       = $urandom;
      bus.i_jump_reg     = ($urandom_range(0, 6) == 0);
      bus.i_pcreg        = $urandom;
      bus.i_halt         = ($urandom_range(0, 40) == 0);
      rst                = ($urandom_range(0, 30) == 0);
      tick();
    end
    clear_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
